// File: rtl/branch_table_updater.sv
// Write-side controller for the branch predictor table: clears the RAM after reset, then
// turns resolved-branch updates into a 3-stage read-modify-write pipeline with write bypass.
module branch_table_updater #(
  parameter int unsigned C_DEPTH     = 512,
  parameter int unsigned C_TAG_WIDTH = 17,
  localparam int unsigned IDX_W      = $clog2(C_DEPTH),
  localparam int unsigned EW         = C_TAG_WIDTH + 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   update_valid,
  output logic                   update_ready,
  input  logic [IDX_W-1:0]       update_index,
  input  logic [C_TAG_WIDTH-1:0] update_tag,
  input  logic                   update_taken,
  output logic                   init_done,
  output logic                   ram_read_en,
  output logic [IDX_W-1:0]       ram_read_addr,
  input  logic [EW-1:0]          ram_read_data,
  output logic                   ram_write_en,
  output logic [IDX_W-1:0]       ram_write_addr,
  output logic [EW-1:0]          ram_write_data
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_DEPTH - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       clr_cnt;
  logic [IDX_W-1:0]       clr_cnt_nxt;

  logic                   s2_valid;
  logic [IDX_W-1:0]       s2_idx;
  logic [C_TAG_WIDTH-1:0] s2_tag;
  logic                   s2_taken;
  logic [EW-1:0]          s2_old;
  logic [EW-1:0]          s2_new;
  logic                   s2_hit;
  logic [1:0]             s2_ctr;

  logic                   w1_valid;
  logic [IDX_W-1:0]       w1_idx;
  logic [EW-1:0]          w1_entry;
  logic                   w2_valid;
  logic [IDX_W-1:0]       w2_idx;
  logic [EW-1:0]          w2_entry;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state: sweep the clear counter across the table once, then stay in RUN
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_nxt = clr_cnt + IDX_W'(1);
      if (clr_cnt == LAST_IDX) begin
        state_nxt = ST_RUN;
      end
    end
  end

  // Outputs: clear writes in CLEAR, pipeline writes in RUN; no write while rst is high
  always_comb begin
    update_ready   = (state == ST_RUN);
    init_done      = (state == ST_RUN);
    ram_write_en   = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    if (!rst) begin
      case (state)
        ST_CLEAR: begin
          ram_write_en   = 1'b1;
          ram_write_addr = clr_cnt;
        end
        ST_RUN: begin
          if (w1_valid) begin
            ram_write_en   = 1'b1;
            ram_write_addr = w1_idx;
            ram_write_data = w1_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_read_en   = update_valid && update_ready;
  assign ram_read_addr = update_index;

  // S2: pick the freshest copy of the entry, then apply the counter update
  always_comb begin
    if (w1_valid && (w1_idx == s2_idx)) begin
      s2_old = w1_entry;
    end else if (w2_valid && (w2_idx == s2_idx)) begin
      s2_old = w2_entry;
    end else begin
      s2_old = ram_read_data;
    end
    s2_hit = s2_old[EW-1] && (s2_old[EW-2:2] == s2_tag);
    s2_ctr = s2_old[1:0];
    if (!s2_hit) begin
      s2_ctr = s2_taken ? 2'b10 : 2'b01;
    end else if (s2_taken && (s2_ctr != 2'b11)) begin
      s2_ctr = s2_ctr + 2'd1;
    end else if (!s2_taken && (s2_ctr != 2'b00)) begin
      s2_ctr = s2_ctr - 2'd1;
    end
    s2_new = {1'b1, s2_tag, s2_ctr};
  end

  // Pipeline valids; rst discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      w1_valid <= 1'b0;
      w2_valid <= 1'b0;
    end else begin
      s2_valid <= ram_read_en;
      w1_valid <= s2_valid;
      w2_valid <= w1_valid;
    end
  end

  // Pipeline payload; W2 keeps the entry written last cycle for the 2-cycle bypass
  always_ff @(posedge clk) begin
    s2_idx   <= update_index;
    s2_tag   <= update_tag;
    s2_taken <= update_taken;
    w1_idx   <= s2_idx;
    w1_entry <= s2_new;
    w2_idx   <= w1_idx;
    w2_entry <= w1_entry;
  end

endmodule

// File: tb/tb_branch_table_updater.sv
// Bench for branch_table_updater: architectural table model with a scoreboard of expected
// RAM writes, directed scenarios with literal counter sequences, and randomized traffic.
module tb_branch_table_updater;

  localparam int DEPTH = 16;
  localparam int TW    = 17;
  localparam int IW    = 4;
  localparam int EW    = TW + 3;

  typedef struct {
    int           cyc;
    logic [IW-1:0] a;
    logic [EW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          update_valid = 1'b0;
  logic          update_ready;
  logic [IW-1:0] update_index = '0;
  logic [TW-1:0] update_tag = '0;
  logic          update_taken = 1'b0;
  logic          init_done;
  logic          ram_read_en;
  logic [IW-1:0] ram_read_addr;
  logic [EW-1:0] ram_read_data;
  logic          ram_write_en;
  logic [IW-1:0] ram_write_addr;
  logic [EW-1:0] ram_write_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rst_cyc = 0;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_q;
  logic [EW-1:0] tab [DEPTH];
  wr_t           pend[$];
  wr_t           wlog[$];

  branch_table_updater #(.C_DEPTH(DEPTH), .C_TAG_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .update_valid   (update_valid),
    .update_ready   (update_ready),
    .update_index   (update_index),
    .update_tag     (update_tag),
    .update_taken   (update_taken),
    .init_done      (init_done),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 1-cycle read, read returns the pre-write contents on a same-edge collision
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= EW'($urandom);
    rd_q <= '0;
  end
  always @(posedge clk) begin
    if (ram_read_en) rd_q <= mem[ram_read_addr];
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
  end
  assign ram_read_data = rd_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] next_entry(input logic [EW-1:0] old, input logic [TW-1:0] tag,
                                               input logic tk);
    int c;
    if (old[EW-1] && old[EW-2:2] == tag) begin
      c = int'(old[1:0]);
      c = tk ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      return {1'b1, tag, 2'(c)};
    end
    return {1'b1, tag, tk ? 2'b10 : 2'b01};
  endfunction

  function automatic logic [31:0] wl_d(input int k);
    if (k < wlog.size()) return 32'(wlog[k].d);
    return 'x;
  endfunction
  function automatic logic [31:0] wl_a(input int k);
    if (k < wlog.size()) return 32'(wlog[k].a);
    return 'x;
  endfunction
  function automatic logic [31:0] wl_c(input int k);
    if (k < wlog.size()) return 32'(wlog[k].cyc);
    return 'x;
  endfunction

  // Every write the DUT issues, including any that would be illegal
  always @(negedge clk) begin
    if (ram_write_en === 1'b1) wlog.push_back('{cyc, ram_write_addr, ram_write_data});
  end

  // Per-cycle compare against the architectural model
  logic          exp_rdy, exp_acc, exp_we;
  logic [IW-1:0] exp_wa;
  logic [EW-1:0] exp_wd, nent;
  always @(negedge clk) begin
    exp_rdy = (cyc >= rst_cyc + DEPTH + 1);
    chk("update_ready", update_ready, exp_rdy);
    chk("init_done", init_done, exp_rdy);
    exp_acc = update_valid && exp_rdy;
    chk("ram_read_en", ram_read_en, exp_acc);
    if (exp_acc) chk("ram_read_addr", ram_read_addr, update_index);
    if (rst) begin
      chk("ram_write_en_rst", ram_write_en, 1'b0);
      pend.delete();
      for (int i = 0; i < DEPTH; i++) tab[i] = '0;
      rst_cyc = cyc;
    end else begin
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      if (cyc - rst_cyc <= DEPTH) begin
        exp_we = 1'b1;
        exp_wa = IW'(cyc - rst_cyc - 1);
      end else if (pend.size() > 0 && pend[0].cyc == cyc) begin
        exp_we = 1'b1;
        exp_wa = pend[0].a;
        exp_wd = pend[0].d;
        void'(pend.pop_front());
      end
      chk("ram_write_en", ram_write_en, exp_we);
      if (exp_we) begin
        chk("ram_write_addr", ram_write_addr, exp_wa);
        chk("ram_write_data", ram_write_data, exp_wd);
      end
      if (exp_acc) begin
        nent = next_entry(tab[update_index], update_tag, update_taken);
        tab[update_index] = nent;
        pend.push_back('{cyc + 2, update_index, nent});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic upd(input logic [IW-1:0] i, input logic [TW-1:0] t, input logic tk);
    update_valid = 1'b1;
    update_index = i;
    update_tag   = t;
    update_taken = tk;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
  endtask

  // seq holds the expected 2-bit counters, oldest write in the most significant pair
  task automatic expect_ctrs(input string nm, input int base, input int n, input logic [IW-1:0] a,
                             input logic [31:0] seq);
    chk({nm, "_count"}, 32'(wlog.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      chk({nm, "_ctr"}, wl_d(base + k) & 32'h3, (seq >> (2 * (n - 1 - k))) & 32'h3);
      chk({nm, "_addr"}, wl_a(base + k), 32'(a));
    end
  endtask

  initial begin
    int base;
    int rc;
    int k;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: clear sweep and init_done timing
    k = 0;
    while (init_done !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t1_init_done", init_done, 1'b1);
    chk("t1_init_cycle", 32'(cyc), 32'd18);
    chk("t1_clear_count", 32'(wlog.size()), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t1_clear_addr", wl_a(i), 32'(i));
      chk("t1_clear_data", wl_d(i), 32'd0);
    end

    // T2: allocate taken, then the same update not taken
    base = wlog.size();
    upd(4'd5, 17'h1ABCD, 1'b1);
    idle(3);
    upd(4'd5, 17'h1ABCD, 1'b0);
    idle(3);
    chk("t2_alloc_data", wl_d(base), 32'({1'b1, 17'h1ABCD, 2'b10}));
    chk("t2_nt_data", wl_d(base + 1), 32'({1'b1, 17'h1ABCD, 2'b01}));
    expect_ctrs("t2", base, 2, 4'd5, 32'b10_01);

    // T3: saturate up, then down, spaced 4 cycles
    base = wlog.size();
    repeat (5) begin
      upd(4'd5, 17'h1ABCD, 1'b1);
      idle(3);
    end
    expect_ctrs("t3_up", base, 5, 4'd5, 32'b10_11_11_11_11);
    base = wlog.size();
    repeat (3) begin
      upd(4'd5, 17'h1ABCD, 1'b0);
      idle(3);
    end
    expect_ctrs("t3_down", base, 3, 4'd5, 32'b10_01_00);

    // T4: back-to-back and 2-cycle spacing on fresh entries
    base = wlog.size();
    repeat (4) upd(4'd9, 17'h00555, 1'b1);
    idle(3);
    expect_ctrs("t4_b2b", base, 4, 4'd9, 32'b10_11_11_11);
    base = wlog.size();
    repeat (4) begin
      upd(4'd10, 17'h00555, 1'b1);
      idle(1);
    end
    idle(3);
    expect_ctrs("t4_gap2", base, 4, 4'd10, 32'b10_11_11_11);

    // T5: tag conflict replaces a saturated entry
    upd(4'd3, 17'h0AAAA, 1'b1);
    idle(3);
    upd(4'd3, 17'h0AAAA, 1'b1);
    idle(3);
    chk("t5_setup", wl_d(wlog.size() - 1), 32'({1'b1, 17'h0AAAA, 2'b11}));
    base = wlog.size();
    upd(4'd3, 17'h15555, 1'b0);
    idle(3);
    chk("t5_replace", wl_d(base), 32'({1'b1, 17'h15555, 2'b01}));

    // T6: reset with two updates in flight
    base = wlog.size();
    upd(4'd7, 17'h00007, 1'b1);
    upd(4'd8, 17'h00008, 1'b1);
    update_valid = 1'b1;
    update_index = 4'd7;
    rst = 1'b1;
    rc = cyc;
    @(posedge clk);
    #1;
    rst = 1'b0;
    update_valid = 1'b0;
    idle(20);
    chk("t6_write_count", 32'(wlog.size() - base), 32'd16);
    chk("t6_first_cyc", wl_c(base), 32'(rc + 1));
    chk("t6_first_addr", wl_a(base), 32'd0);
    chk("t6_last_addr", wl_a(base + 15), 32'd15);
    chk("t6_ready_back", update_ready, 1'b1);

    // Randomized traffic with heavy index reuse and one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      update_valid = ($urandom_range(0, 9) < 7);
      update_index = IW'($urandom_range(0, ((i % 50) < 25) ? 3 : 15));
      update_tag   = 17'h1ABCD + TW'($urandom_range(0, 1));
      update_taken = 1'($urandom_range(0, 1));
      rst          = (i == 200);
      @(posedge clk);
      #1;
    end
    update_valid = 1'b0;
    rst = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
